// File: rtl/window_fetch_pkg.sv
// Shared constants and FSM state type for the window fetch stage.
// The memory-control window muxes reuse the width constants defined here.
package window_fetch_pkg;

    localparam int unsigned WF_DATA_W  = 16;  // word width
    localparam int unsigned WF_ADDR_W  = 11;  // RAM address width
    localparam int unsigned WF_WORDS   = 5;   // words per window
    localparam int unsigned WF_MEM_LAT = 1;   // RAM read latency (1 or 2)
    localparam int unsigned WF_TAG_W   = 3;   // slot tag width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/window_capture.sv
// Tagged capture register: one DATA_W slot per window word, written by slot
// tag and cleared as a whole at the start of each window.
module window_capture #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 5,
    parameter int unsigned TAG_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [TAG_W-1:0]          wr_tag,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W*WORDS-1:0]   win_data
);

    logic [DATA_W*WORDS-1:0] cap_q;

    // Clear has priority; otherwise the tagged slot takes the returned word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
        end else if (clear) begin
            cap_q <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (wr_tag == TAG_W'(i)) begin
                    cap_q[i*DATA_W +: DATA_W] <= wr_data;
                end
            end
        end
    end

    assign win_data = cap_q;

endmodule

// File: rtl/window_fetch.sv
// Window fetch stage: issues WORDS consecutive reads from a single-port RAM,
// captures the returned words by slot and presents them as one packed window.
// Optional feature macro: WINDOW_ZERO_PAD_EN (zero-pads words past last_addr).
module window_fetch
    import window_fetch_pkg::*;
#(
    parameter int unsigned DATA_W  = WF_DATA_W,
    parameter int unsigned ADDR_W  = WF_ADDR_W,
    parameter int unsigned WORDS   = WF_WORDS,
    parameter int unsigned MEM_LAT = WF_MEM_LAT,
    parameter int unsigned TAG_W   = WF_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        last_addr,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_read_en,
    output logic                     mem_write_enable,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W*WORDS-1:0]  win_data,
    output logic                     win_valid,
    input  logic                     win_ready
);

    fetch_state_t       state, state_nx;
    logic [TAG_W-1:0]   cnt;
    logic [ADDR_W-1:0]  base_q;
    logic               issue_last;
    logic               drain_done;
    logic               start_ok;

    logic [ADDR_W-1:0]  slot_base;
    logic [TAG_W-1:0]   slot_k;
    logic [ADDR_W-1:0]  slot_addr;
    logic               slot_live;

    logic [MEM_LAT-1:0] tag_v;
    logic [TAG_W-1:0]   tag_k [MEM_LAT];

`ifdef WINDOW_ZERO_PAD_EN
    logic [ADDR_W-1:0]  last_q;
    logic [ADDR_W-1:0]  slot_last;
`else
    logic               unused_last;
    assign unused_last = ^last_addr;
`endif

    assign start_ok         = (state == IDLE) && start;
    assign issue_last       = (cnt == TAG_W'(WORDS - 1));
    assign drain_done       = (cnt == TAG_W'(MEM_LAT));
    assign mem_write_enable = 1'b0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; DRAIN spans MEM_LAT+1 cycles so the last word is settled in HOLD.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)      state_nx = ISSUE;
            ISSUE:   if (issue_last) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = HOLD;
            HOLD:    if (win_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy      = (state != IDLE);
        win_valid = (state == HOLD);
    end

    // Address and pad decision for the slot presented in the next cycle.
    always_comb begin
        slot_base = (state == IDLE) ? base_addr : base_q;
        slot_k    = (state == IDLE) ? '0 : cnt + TAG_W'(1);
        slot_addr = slot_base + ADDR_W'(slot_k);
`ifdef WINDOW_ZERO_PAD_EN
        slot_last = (state == IDLE) ? last_addr : last_q;
        slot_live = ({1'b0, slot_base} + (ADDR_W+1)'(slot_k)) <= {1'b0, slot_last};
`else
        slot_live = 1'b1;
`endif
    end

    // Request latching, slot/drain counter and registered RAM read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_read_en <= 1'b0;
`ifdef WINDOW_ZERO_PAD_EN
            last_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        cnt         <= '0;
                        mem_addr    <= slot_addr;
                        mem_read_en <= slot_live;
`ifdef WINDOW_ZERO_PAD_EN
                        last_q      <= last_addr;
`endif
                    end
                end
                ISSUE: begin
                    if (issue_last) begin
                        cnt         <= '0;
                        mem_read_en <= 1'b0;
                    end else begin
                        cnt         <= slot_k;
                        mem_addr    <= slot_addr;
                        mem_read_en <= slot_live;
                    end
                end
                DRAIN:   cnt <= cnt + TAG_W'(1);
                default: ;
            endcase
        end
    end

    // Return-tag pipeline: slot index and read strobe delayed by the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) tag_k[i] <= '0;
        end else begin
            tag_v[0] <= mem_read_en;
            tag_k[0] <= cnt;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
        end
    end

    window_capture #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .wr_en    (tag_v[MEM_LAT-1]),
        .wr_tag   (tag_k[MEM_LAT-1]),
        .wr_data  (mem_rdata),
        .win_data (win_data)
    );

endmodule
